lm_display_scheduler: RTL and testbench

//  Time-shares the board LEDs between three message sources: UART data, UART errors, CM errors.
//  A round-robin arbiter accepts one code at a time over a valid/ready handshake.

---
 rtl/lm_display_if.sv | 10 +
 rtl/lm_display_scheduler.sv | 90 +++++++++
 tb/tb_lm_display_scheduler.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/lm_display_if.sv
// lm_display_if: valid/ready code request bundle from the three LED message sources
interface lm_display_if #(
  parameter int WIDTH_CODE = 8
);
  logic [2:0]              req_valid;
  logic [3*WIDTH_CODE-1:0] req_code;
  logic [2:0]              req_ready;
  modport master (output req_valid, req_code, input req_ready);
  modport slave (input req_valid, req_code, output req_ready);
endinterface

// File: rtl/lm_display_scheduler.sv
// lm_display_scheduler: round-robin time-sharing of the LEDs between UART data, UART err and CM err codes
// Optional sticky error flags on leds[WIDTH_CODE+4:WIDTH_CODE+3] are enabled by LM_STICKY_ERROR_EN.
module lm_display_scheduler #(
  parameter int WIDTH_CODE  = 8,
  parameter int WIDTH_LEDS  = 16,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 5_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  lm_display_if.slave           req,
  input  logic                  clear_sticky,
  output logic [WIDTH_LEDS-1:0] leds,
  output logic                  busy,
  output logic [1:0]            active_src
);
  localparam int MAX_CYCLES = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] last_grant, grant, p0, p1, p2, src_q, src_n;
  logic [3:0] valid_ext;
  logic [WIDTH_CODE-1:0] code_q, code_n, grant_code;
  logic accept;
  logic [1:0] sticky_n;
  logic [WIDTH_LEDS-1:0] leds_n;
  // Priority scan starts one past the last served source
  always_comb begin
    valid_ext = {1'b0, req.req_valid};
    p0 = last_grant == 2'd2 ? 2'd0 : last_grant + 2'd1;
    p1 = p0 == 2'd2 ? 2'd0 : p0 + 2'd1;
    p2 = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
    grant = valid_ext[p0] ? p0 : valid_ext[p1] ? p1 : p2;
    grant_code = grant == 2'd0 ? req.req_code[WIDTH_CODE-1:0]
               : grant == 2'd1 ? req.req_code[2*WIDTH_CODE-1:WIDTH_CODE]
               : req.req_code[3*WIDTH_CODE-1:2*WIDTH_CODE];
    accept = state == IDLE && |req.req_valid;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 2'd2;
      code_q     <= '0;
      src_q      <= '0;
      leds       <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      code_q <= code_n;
      src_q  <= src_n;
      leds   <= leds_n;
      if (accept) last_grant <= grant;
    end
  always_comb begin
    state_n = state == IDLE ? (accept ? HOLD : IDLE)
            : state == HOLD ? (cnt == HOLD_LAST ? (GAP_CYCLES > 0 ? GAP : IDLE) : HOLD)
            : (cnt == GAP_LAST ? IDLE : GAP);
    cnt_n  = (state_n != state || state == IDLE) ? '0 : cnt + CW'(1);
    code_n = accept ? grant_code : code_q;
    src_n  = accept ? grant : src_q;
  end
  // LEDs are registered, so they are built from the next-cycle view
  always_comb begin
    req.req_ready = {accept && grant == 2'd2, accept && grant == 2'd1, accept && grant == 2'd0};
    busy = state != IDLE;
    active_src = state == HOLD ? src_q : 2'd3;
    leds_n = '0;
    leds_n[WIDTH_LEDS-1] = state_n != IDLE;
    if (state_n == HOLD) begin
      leds_n[WIDTH_CODE-1:0] = code_n;
      leds_n[WIDTH_CODE+2:WIDTH_CODE] = {src_n == 2'd2, src_n == 2'd1, src_n == 2'd0};
    end
    leds_n[WIDTH_CODE+4:WIDTH_CODE+3] = sticky_n;
  end
`ifdef LM_STICKY_ERROR_EN
  logic [1:0] sticky;
  always_ff @(posedge clk or posedge rst)
    if (rst) sticky <= 2'b00;
    else sticky <= sticky_n;
  assign sticky_n = (clear_sticky ? 2'b00 : sticky) | {accept && grant == 2'd2, accept && grant == 2'd1};
`else
  logic unused_clear;
  assign unused_clear = clear_sticky;
  assign sticky_n = 2'b00;
`endif
endmodule

// File: tb/tb_lm_display_scheduler.sv
// tb_lm_display_scheduler: table vectors, directed corner cases and a random run against a slot-timing model
module tb_lm_display_scheduler;
  localparam int WC = 8, WL = 16, H = 4, G = 2;
`ifdef LM_STICKY_ERROR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, clear_sticky = 1'b0;
  logic [WL-1:0] leds, leds0;
  logic busy, busy0;
  logic [1:0] act, act0;
  lm_display_if #(.WIDTH_CODE(WC)) ifm();
  lm_display_if #(.WIDTH_CODE(WC)) ifz();
  lm_display_scheduler #(.WIDTH_CODE(WC), .WIDTH_LEDS(WL), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .req(ifm), .clear_sticky(clear_sticky),
    .leds(leds), .busy(busy), .active_src(act));
  lm_display_scheduler #(.WIDTH_CODE(WC), .WIDTH_LEDS(WL), .HOLD_CYCLES(H), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(ifz), .clear_sticky(clear_sticky),
    .leds(leds0), .busy(busy0), .active_src(act0));
  always #5 clk = ~clk;
  int n_checks = 0, n_fail = 0;
  // Model: a slot is described by the edge that accepted it; position in the slot gives the phase
  int m_last, m_edge, m_acc, m_src, m_got;
  logic [WC-1:0] m_code;
  logic [1:0] m_sticky;
  int acc_src_q[$], acc_edge_q[$];
  typedef struct {
    logic [2:0]  valid;
    logic [2:0]  ready;
    logic [15:0] leds;
    logic [1:0]  src;
  } vec_t;
  vec_t tv[7];
  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask
  function automatic int model_grant();
    if (m_edge - m_acc < H + G) return -1;
    for (int k = 1; k <= 3; k++)
      if (ifm.req_valid[(m_last + k) % 3]) return (m_last + k) % 3;
    return -1;
  endfunction
  function automatic logic [WL-1:0] exp_leds();
    int d;
    logic [WL-1:0] v;
    d = m_edge - m_acc;
    v = '0;
    if (d < H) begin
      v[WC-1:0] = m_code;
      v[WC + m_src] = 1'b1;
    end
    v[WL-1] = d < H + G;
    v[WC+4:WC+3] = STICKY ? m_sticky : 2'b00;
    return v;
  endfunction
  function automatic int oh2i(input logic [2:0] r);
    return r == 3'b001 ? 0 : r == 3'b010 ? 1 : r == 3'b100 ? 2 : 3;
  endfunction
  task automatic model_reset();
    m_last = 2; m_edge = 0; m_acc = -100; m_src = 0; m_code = '0; m_sticky = 2'b00; m_got = -1;
  endtask
  task automatic tick();
    int g;
    logic clr;
    #1;
    g = model_grant();
    chk("ready", {29'b0, ifm.req_ready}, g >= 0 ? 32'(1 << g) : 32'd0);
    if (ifm.req_ready != 3'b000) begin
      acc_src_q.push_back(oh2i(ifm.req_ready));
      acc_edge_q.push_back(m_edge);
    end
    clr = clear_sticky;
    @(posedge clk);
    m_edge++;
    if (clr) m_sticky = 2'b00;
    m_got = g;
    if (g >= 0) begin
      m_acc = m_edge; m_src = g; m_last = g; m_code = ifm.req_code[g*WC +: WC];
      if (g > 0) m_sticky[g-1] = 1'b1;
    end
    @(negedge clk);
    chk("leds", {16'b0, leds}, {16'b0, exp_leds()});
    chk("busy", {31'b0, busy}, (m_edge - m_acc < H + G) ? 32'd1 : 32'd0);
    chk("active_src", {30'b0, act}, (m_edge - m_acc < H) ? 32'(m_src) : 32'd3);
  endtask
  task automatic do_reset();
    rst = 1'b1; ifm.req_valid = 3'b000; ifz.req_valid = 3'b000; clear_sticky = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_leds", {16'b0, leds}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_src", {30'b0, act}, 32'd3);
    chk("rst_leds0", {16'b0, leds0}, 32'd0);
    rst = 1'b0;
    model_reset();
    acc_src_q.delete();
    acc_edge_q.delete();
  endtask
  initial begin
    int exp_ord[4];
    exp_ord = '{0, 1, 2, 0};
    tv[0] = '{3'b001, 3'b001, 16'h81A5, 2'd0};
    tv[1] = '{3'b001, 3'b000, 16'h81A5, 2'd0};
    tv[2] = '{3'b001, 3'b000, 16'h81A5, 2'd0};
    tv[3] = '{3'b001, 3'b000, 16'h81A5, 2'd0};
    tv[4] = '{3'b001, 3'b000, 16'h8000, 2'd3};
    tv[5] = '{3'b001, 3'b000, 16'h8000, 2'd3};
    tv[6] = '{3'b000, 3'b000, 16'h0000, 2'd3};
    ifm.req_valid = 3'b000; ifm.req_code = '0; ifz.req_valid = 3'b000; ifz.req_code = '0;
    do_reset();
    ifm.req_code = 24'h0000A5;
    foreach (tv[i]) begin
      ifm.req_valid = tv[i].valid;
      #1;
      chk("t1_ready", {29'b0, ifm.req_ready}, {29'b0, tv[i].ready});
      @(posedge clk);
      @(negedge clk);
      chk("t1_leds", {16'b0, leds}, {16'b0, tv[i].leds});
      chk("t1_busy", {31'b0, busy}, {31'b0, tv[i].leds[15]});
      chk("t1_src", {30'b0, act}, {30'b0, tv[i].src});
    end
    do_reset();
    ifm.req_code = {8'h33, 8'h22, 8'h11};
    ifm.req_valid = 3'b111;
    repeat (22) tick();
    chk("t2_count", acc_src_q.size(), 4);
    for (int i = 0; i < 4 && i < acc_src_q.size(); i++) begin
      chk("t2_order", acc_src_q[i], exp_ord[i]);
      if (i > 0) chk("t2_spacing", acc_edge_q[i] - acc_edge_q[i-1], 7);
    end
    do_reset();
    ifm.req_code = {8'h3C, 8'h2B, 8'h1A};
    ifm.req_valid = 3'b101;
    tick();
    ifm.req_valid = 3'b100;
    tick();
    ifm.req_valid = 3'b000;
    tick();
    ifm.req_valid = 3'b010;
    repeat (7) tick();
    chk("t3_count", acc_src_q.size(), 2);
    chk("t3_second", acc_src_q.size() > 1 ? acc_src_q[1] : 9, 1);
    do_reset();
    ifz.req_code = {8'h00, 8'h5A, 8'h00};
    ifz.req_valid = 3'b010;
    for (int k = 0; k < 15; k++) begin
      #1;
      chk("t4_ready", {29'b0, ifz.req_ready}, (k % 5 == 0) ? 32'd2 : 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("t4_leds", {16'b0, leds0}, ((k % 5 == 4) ? 32'h0000 : 32'h825A) | {20'b0, STICKY, 11'b0});
    end
    do_reset();
    ifm.req_code = {8'h77, 8'h66, 8'h55};
    ifm.req_valid = 3'b010;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("t5_async_leds", {16'b0, leds}, 32'd0);
    chk("t5_async_busy", {31'b0, busy}, 32'd0);
    chk("t5_async_src", {30'b0, act}, 32'd3);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    ifm.req_valid = 3'b111;
    #1;
    chk("t5_first_grant", {29'b0, ifm.req_ready}, 32'd1);
    repeat (3) tick();
    do_reset();
    ifm.req_code = {8'hE2, 8'h00, 8'h00};
    ifm.req_valid = 3'b100;
    tick();
    ifm.req_valid = 3'b000;
    repeat (6) tick();
    chk("t6_sticky_held", {31'b0, leds[12]}, {31'b0, STICKY});
    clear_sticky = 1'b1;
    tick();
    clear_sticky = 1'b0;
    chk("t6_sticky_cleared", {31'b0, leds[12]}, 32'd0);
    tick();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int s = 0; s < 3; s++)
        if (!ifm.req_valid[s] && $urandom_range(0, 3) == 0) begin
          ifm.req_valid[s] = 1'b1;
          ifm.req_code[s*WC +: WC] = 8'($urandom);
        end
      clear_sticky = $urandom_range(0, 15) == 0;
      tick();
      if (m_got >= 0 && $urandom_range(0, 1) == 0) ifm.req_valid[m_got] = 1'b0;
    end
    clear_sticky = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
